sigmoid_share_arbiter: RTL and testbench
========================================

Name: sigmoid_share_arbiter

Overview:
- Shares one pipelined sigmoid unit (17-bit x in, 33-bit y out, fixed latency, no stall) among N_REQ requesters.
- Round-robin arbitration accepts at most one request per cycle and drives the unit's x input from a register.
- A tag shift register tracks each in-flight operand so that every result returns on a common response port labelled with its requester ID.
- Sits between the CNN activation stage's parallel lanes and the single sigmoid instance.

Parameters:
- WIDTH_X, 17, operand width (two's complement fixed point)
- WIDTH_Y, 33, result width
- N_REQ, 4, number of requesters (2..2**ID_W)
- ID_W, 2, requester ID width
- LAT, 3, sigmoid unit latency in cycles from sig_x to sig_y (>=1)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight operations
- req_valid  in  N_REQ  request valid, one bit per requester
- req_x  in  N_REQ*WIDTH_X  operands packed; requester i occupies bits [i*WIDTH_X +: WIDTH_X]
- req_ready  out  N_REQ  one-hot grant; transfer occurs when valid&ready
- sig_x  out  WIDTH_X  operand to the sigmoid unit, registered
- sig_y  in  WIDTH_Y  result from the sigmoid unit
- rsp_valid  out  1  response valid (single-cycle pulse per result)
- rsp_id  out  ID_W  requester index of the response
- rsp_y  out  WIDTH_Y  sigmoid result
- busy  out  1  any tag valid or rsp_valid high

Behaviour:
- Reset (rstn low, async): sig_x=0, all tag valid bits=0, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_y=0. req_ready is combinational and reads 0 while no requests are valid.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - req_ready depends on req_valid. Requesters must not make valid depend on ready.
- Accept in cycle A (some i granted, flush=0):
  - At the edge: sig_x <= req_x[i].
  - Tag stage 0 <= {valid=1, id=i}.
  - rr_ptr <= (i+1) mod N_REQ.
- No accept:
  - sig_x holds its value.
  - Tag stage 0 valid <= 0.
  - rr_ptr holds.
- Tag pipeline:
  - LAT stages shift every cycle, unconditionally. The sigmoid unit never stalls.
  - Stage k at cycle A+1+k is aligned with the operand applied at cycle A+1.
  - The last stage coincides with sig_y valid in cycle A+1+LAT.
- Response:
  - At the end of cycle A+1+LAT: rsp_valid <= last-stage valid, rsp_id <= last-stage id, rsp_y <= sig_y.
  - rsp_valid is therefore high in cycle A+2+LAT. Total latency = LAT+2 cycles from handshake.
  - When rsp_valid=0, rsp_y and rsp_id hold their previous values.
- Throughput: one accept per cycle sustained. Responses leave in acceptance order.
- flush=1:
  - req_ready forced to 0 (no accept that cycle).
  - All tag valid bits cleared at the edge, and rsp_valid=0 the following cycle.
  - rr_ptr and sig_x hold.
  - Results of flushed operations are never reported, even if sig_y later carries them.
- Reset mid-operation: in-flight operations are discarded with no response; behaviour is identical to the power-up reset state.
- rr_ptr wraps: after granting N_REQ-1 it becomes 0.
- Requester behaviour:
  - A requester that drops valid without receiving ready loses nothing (no state is held).
  - A requester held off must keep req_x stable while valid is high.

Optional Feature:
- Macro: SIGMOID_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins, and rr_ptr is removed (no register).
- Undefined (default): round-robin as above.
- Latency, tag and flush behaviour are identical in both builds.

Test Plan:
- Single request: req_valid=0001, x=0 accepted in cycle 0 with LAT=3 -> rsp_valid only in cycle 5, rsp_id=0, rsp_y equals the sigmoid model's y(0); busy high during cycles 1..5.
- All four requesters held valid for 8 cycles with distinct x (-65535, -100, 100, 65535) -> grants 0,1,2,3,0,1,2,3; rsp_id follows the same sequence on consecutive cycles 5..12; each rsp_y matches its operand.
- rr_ptr=2 with req_valid=1010 -> requester 3 granted first, then 1. With SIGMOID_ARB_FIXED_PRIO_EN -> requester 1 granted on every cycle while valid.
- Three accepts in cycles 0..2, flush=1 in cycle 3 -> no rsp_valid in cycles 4..8; req_ready=0 in cycle 3; a new accept in cycle 4 responds in cycle 9.
- rstn pulsed low in cycle 2 with two operations in flight -> all outputs return to reset values immediately, no responses appear, and the next accept is granted starting from requester 0.
- Sweep x from -65535 to 65535 in steps of 100 on requester 2 alone, valid every cycle -> one response per cycle after the 5-cycle fill, all with rsp_id=2, in order, with no gaps.

Source files
------------

// File: rtl/sigmoid_share_arbiter.sv
// sigmoid_share_arbiter
//   Shares one fixed-latency, non-stalling sigmoid unit among N_REQ requesters.
//   A round-robin arbiter accepts at most one operand per cycle and registers
//   it onto sig_x. A tag shift register carries each operand's requester ID
//   alongside the unit's pipeline, so every result leaves on the common
//   response port labelled with its owner. Handshake-to-response latency is
//   LAT+2 cycles.
//
//   Build option: define SIGMOID_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index wins, no rotating pointer). The default build is round-robin.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   flush      synchronous kill of every in-flight operation
//   req_valid  per-requester valid
//   req_x      packed operands, requester i at [i*WIDTH_X +: WIDTH_X]
//   req_ready  one-hot grant (combinational from req_valid/flush/pointer)
//   sig_x      registered operand to the sigmoid unit
//   sig_y      result from the sigmoid unit
//   rsp_valid  single-cycle response pulse
//   rsp_id     requester index of the response
//   rsp_y      sigmoid result
//   busy       any tag in flight or a response presented
module sigmoid_share_arbiter #(
  parameter int unsigned WIDTH_X = 17,
  parameter int unsigned WIDTH_Y = 33,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LAT     = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH_X-1:0] req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic [WIDTH_X-1:0]       sig_x,
  input  logic [WIDTH_Y-1:0]       sig_y,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH_Y-1:0]       rsp_y,
  output logic                     busy
);

  // Stage 0 lines up with sig_x; stage LAT lines up with sig_y.
  localparam int unsigned NSTG = LAT + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  tag_t              tag_q [NSTG];
  logic [WIDTH_X-1:0] x_arr [N_REQ];
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [WIDTH_X-1:0] grant_x;
  logic [ID_W-1:0]   scan_base;
  logic [ID_W-1:0]   sel;

  // Unpack the operand bus into lanes.
  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign x_arr[g] = req_x[g*WIDTH_X +: WIDTH_X];
  end

`ifdef SIGMOID_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [ID_W-1:0] rr_ptr;

  assign scan_base = rr_ptr;

  // Pointer moves to the requester after the one just granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end
`endif

  // Scan from scan_base, wrapping; first valid requester wins. flush blocks all.
  always_comb begin
    req_ready = '0;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_x   = '0;
    sel       = '0;
    if (!flush) begin
      for (int unsigned off = 0; off < N_REQ; off++) begin
        sel = ID_W'((32'(scan_base) + off) % N_REQ);
        if (!grant_vld && req_valid[sel]) begin
          grant_vld      = 1'b1;
          grant_id       = sel;
          grant_x        = x_arr[sel];
          req_ready[sel] = 1'b1;
        end
      end
    end
  end

  // Operand register, tag pipeline and response register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_x     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      for (int unsigned k = 0; k < NSTG; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (grant_vld) begin
        sig_x <= grant_x;
      end
      tag_q[0] <= tag_t'{vld: grant_vld, id: grant_id};
      for (int unsigned k = 1; k < NSTG; k++) begin
        tag_q[k] <= flush ? '0 : tag_q[k-1];
      end
      // A flush also suppresses the result already aligned with sig_y.
      rsp_valid <= tag_q[NSTG-1].vld & ~flush;
      if (tag_q[NSTG-1].vld && !flush) begin
        rsp_id <= tag_q[NSTG-1].id;
        rsp_y  <= sig_y;
      end
    end
  end

  // Activity indicator over every tag stage plus the response register.
  always_comb begin
    busy = rsp_valid;
    for (int unsigned k = 0; k < NSTG; k++) begin
      busy = busy | tag_q[k].vld;
    end
  end

endmodule

// File: tb/tb_sigmoid_share_arbiter.sv
// Testbench for sigmoid_share_arbiter: a stand-in sigmoid unit plus a
// queue-based reference of outstanding operations, compared every cycle.
module tb_sigmoid_share_arbiter;

  localparam int unsigned WX  = 17;
  localparam int unsigned WY  = 33;
  localparam int unsigned NR  = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned LAT = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR*WX-1:0]  req_x;
  logic [NR-1:0]     req_ready;
  logic [WX-1:0]     sig_x;
  logic [WY-1:0]     sig_y;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [WY-1:0]     rsp_y;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sigmoid_share_arbiter #(
    .WIDTH_X(WX), .WIDTH_Y(WY), .N_REQ(NR), .ID_W(IW), .LAT(LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .sig_x(sig_x), .sig_y(sig_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
  );

  // Stand-in sigmoid: any injective map is enough to tie results to operands.
  function automatic logic [WY-1:0] sig_fn(input logic [WX-1:0] x);
    return {~x, x[15:0] ^ 16'hA5C3};
  endfunction

  logic [WX-1:0] unit_pipe [LAT];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < LAT; k++) unit_pipe[k] <= '0;
    end else begin
      unit_pipe[0] <= sig_x;
      for (int k = 1; k < LAT; k++) unit_pipe[k] <= unit_pipe[k-1];
    end
  end
  assign sig_y = sig_fn(unit_pipe[LAT-1]);

  typedef struct packed {
    logic [NR-1:0] ready;
    logic          rspv;
    logic [IW-1:0] rid;
    logic [WY-1:0] ry;
    logic          busy;
    logic [WX-1:0] sx;
  } obs_t;

  // Reference: list of accepted operations with the cycle their response is due.
  typedef struct {
    int            due;
    int            id;
    logic [WY-1:0] y;
  } pend_t;

  pend_t         q[$];
  int            m_ptr;
  int            m_cycle = 0;
  logic [IW-1:0] m_last_id;
  logic [WY-1:0] m_last_y;
  logic [WX-1:0] m_sigx;

  function automatic logic [NR*WX-1:0] pack4(input int a, input int b, input int c, input int d);
    return {WX'(d), WX'(c), WX'(b), WX'(a)};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr     = 0;
    m_last_id = '0;
    m_last_y  = '0;
    m_sigx    = '0;
  endtask

  // Expected outputs for the current cycle, then advance by one cycle.
  task automatic model_cycle(input logic [NR-1:0] v, input logic [NR*WX-1:0] x,
                             input logic fl, output obs_t e);
    int g;
    int start;
    g = -1;
`ifdef SIGMOID_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (!fl) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (start + k) % NR;
        if (g < 0 && v[i]) g = i;
      end
    end
    e = '0;
    if (g >= 0) e.ready[g] = 1'b1;
    e.rspv = (q.size() > 0) && (q[0].due == m_cycle);
    e.rid  = e.rspv ? IW'(q[0].id) : m_last_id;
    e.ry   = e.rspv ? q[0].y : m_last_y;
    e.busy = (q.size() > 0) && (q[0].due - int'(LAT) - 1 <= m_cycle);
    e.sx   = m_sigx;
    if (e.rspv) begin
      m_last_id = e.rid;
      m_last_y  = e.ry;
      void'(q.pop_front());
    end
    if (fl) q.delete();
    if (g >= 0) begin
      pend_t p;
      p.due  = m_cycle + int'(LAT) + 2;
      p.id   = g;
      p.y    = sig_fn(x[g*WX +: WX]);
      q.push_back(p);
      m_sigx = x[g*WX +: WX];
      m_ptr  = (g + 1) % NR;
    end
    m_cycle++;
  endtask

  // Drive one cycle from a negedge and sample outputs just after driving.
  task automatic tick(input logic [NR-1:0] v, input logic [NR*WX-1:0] x,
                      input logic fl, output obs_t o);
    req_valid = v;
    req_x     = x;
    flush     = fl;
    #1;
    o.ready = req_ready;
    o.rspv  = rsp_valid;
    o.rid   = rsp_id;
    o.ry    = rsp_y;
    o.busy  = busy;
    o.sx    = sig_x;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t o;
    rstn = 1'b0; flush = 1'b0; req_valid = '0; req_x = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    o = {req_ready, rsp_valid, rsp_id, rsp_y, busy, sig_x};
    n_checks++;
    if (o !== obs_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=0", o);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single();
    obs_t o, e;
    logic [NR-1:0] v;
    for (int c = 0; c < 8; c++) begin
      v = (c == 0) ? 4'b0001 : 4'b0000;
      tick(v, '0, 1'b0, o);
      model_cycle(v, '0, 1'b0, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL single c=%0d got=%h want=%h", c, o, e); end
    end
  endtask

  task automatic test_all_rr();
    obs_t o, e;
    logic [NR-1:0] v;
    logic [NR*WX-1:0] x;
    x = pack4(-65535, -100, 100, 65535);
    for (int c = 0; c < 8 + int'(LAT) + 3; c++) begin
      v = (c < 8) ? 4'b1111 : 4'b0000;
      tick(v, x, 1'b0, o);
      model_cycle(v, x, 1'b0, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL all_rr c=%0d got=%h want=%h", c, o, e); end
    end
  endtask

  task automatic test_pattern_1010();
    obs_t o, e;
    logic [NR-1:0] v;
    logic [NR*WX-1:0] x;
    x = pack4(11, 222, 3333, -4444);
    for (int c = 0; c < 5 + int'(LAT) + 3; c++) begin
      v = (c == 0) ? 4'b0010 : (c < 5) ? 4'b1010 : 4'b0000;
      tick(v, x, 1'b0, o);
      model_cycle(v, x, 1'b0, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL pat1010 c=%0d got=%h want=%h", c, o, e); end
    end
  endtask

  task automatic test_flush();
    obs_t o, e;
    logic [NR-1:0] v;
    logic fl;
    logic [NR*WX-1:0] x;
    for (int c = 0; c < 12; c++) begin
      x  = pack4(c * 7 - 30, c * 13, -c * 17, c + 1);
      v  = (c <= 4) ? 4'b0101 : 4'b0000;
      fl = (c == 3);
      tick(v, x, fl, o);
      model_cycle(v, x, fl, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL flush c=%0d got=%h want=%h", c, o, e); end
    end
  endtask

  task automatic test_reset_midop();
    obs_t o, e;
    logic [NR-1:0] v;
    logic [NR*WX-1:0] x;
    x = pack4(500, -600, 700, -800);
    for (int c = 0; c < 2; c++) begin
      v = (c == 0) ? 4'b0100 : 4'b1000;
      tick(v, x, 1'b0, o);
      model_cycle(v, x, 1'b0, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rst_mid pre c=%0d got=%h want=%h", c, o, e); end
    end
    rstn = 1'b0; req_valid = '0;
    #1;
    o = {req_ready, rsp_valid, rsp_id, rsp_y, busy, sig_x};
    n_checks++;
    if (o !== obs_t'(0)) begin n_fail++; $display("FAIL rst_mid async got=%h want=0", o); end
    model_reset();
    #1 rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      v = (c == 0) ? 4'b1111 : 4'b0000;
      tick(v, x, 1'b0, o);
      model_cycle(v, x, 1'b0, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rst_mid post c=%0d got=%h want=%h", c, o, e); end
    end
  endtask

  task automatic test_sweep();
    obs_t o, e;
    logic [NR-1:0] v;
    logic [NR*WX-1:0] x;
    int val;
    val = -65535;
    for (int c = 0; c < 1311 + int'(LAT) + 3; c++) begin
      v = (val <= 65535) ? 4'b0100 : 4'b0000;
      x = pack4(0, 0, val, 0);
      tick(v, x, 1'b0, o);
      model_cycle(v, x, 1'b0, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sweep c=%0d got=%h want=%h", c, o, e); end
      val += 100;
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [NR-1:0] v, prev_v, prev_g;
    logic [NR*WX-1:0] x;
    logic fl;
    int lane [NR];
    prev_v = '0; prev_g = '0;
    for (int i = 0; i < NR; i++) lane[i] = 0;
    for (int c = 0; c < 400; c++) begin
      v  = (c < 390) ? NR'($urandom) : '0;
      fl = (c < 390) && ($urandom_range(0, 15) == 0);
      // Held-off requesters keep their operand; others may change it.
      for (int i = 0; i < NR; i++)
        if (!(prev_v[i] && !prev_g[i])) lane[i] = int'($urandom_range(0, 131071)) - 65536;
      x = pack4(lane[0], lane[1], lane[2], lane[3]);
      tick(v, x, fl, o);
      model_cycle(v, x, fl, e);
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL random c=%0d got=%h want=%h", c, o, e); end
      prev_v = v;
      prev_g = e.ready;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_pattern_1010();
    test_flush();
    test_reset_midop();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
